draw_rect_text: RTL and testbench

DRAW_RECT_TEXT -- requirements
Module: draw_rect_text

---
 rtl/draw_rect_text.sv | 174 +++++++++++++++++
 tb/tb_draw_rect_text.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/draw_rect_text.sv
// Character-cell text overlay: maps each pixel to a text cell, fetches code and glyph
// line through external RAM/ROM, and composites FG/BG with a blinking cursor cell.
module draw_rect_text #(
    parameter int          XPOS         = 850,
    parameter int          YPOS         = 30,
    parameter int          COLS         = 16,
    parameter int          ROWS         = 16,
    parameter int          SCALE        = 1,
    parameter logic [11:0] FG_COLOR     = 12'hfff,
    parameter logic [11:0] BG_COLOR     = 12'h000,
    parameter bit          BG_OPAQUE    = 1'b0,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] hcount_in,
    input  logic [15:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    output logic [7:0]  char_col,
    output logic [7:0]  char_row,
    input  logic [6:0]  char_code,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_line,
    input  logic        cursor_en,
    input  logic [7:0]  cursor_col,
    input  logic [7:0]  cursor_row,
    output logic [15:0] hcount_out,
    output logic [15:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic        blink_phase
);
    localparam int SH = (SCALE == 4) ? 2 : (SCALE == 2) ? 1 : 0;
    localparam logic [31:0] X_LO = 32'(XPOS);
    localparam logic [31:0] X_HI = 32'(XPOS + COLS * 8 * SCALE);
    localparam logic [31:0] Y_LO = 32'(YPOS);
    localparam logic [31:0] Y_HI = 32'(YPOS + ROWS * 16 * SCALE);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic {PHASE_OFF = 1'b0, PHASE_ON = 1'b1} phase_t;

    logic [15:0] rel_x, rel_y;
    logic [7:0]  col, row;
    logic        in_box, pix;
    logic [11:0] fg_c, bg_c;

    logic [7:0]  char_col_q, char_col_d, char_row_q, char_row_d;
    logic [10:0] font_addr_q, font_addr_d;
    logic [11:0] rgb1_q, rgb1_d, rgb2_q, rgb2_d, rgb_out_q, rgb_out_d;
    logic        inbox1_q, inbox1_d, inbox2_q, inbox2_d;
    logic        en1_q, en1_d, en2_q, en2_d;
    logic        cur1_q, cur1_d, cur2_q, cur2_d;
    logic [3:0]  line1_q, line1_d;
    logic [2:0]  bit1_q, bit1_d, bit2_q, bit2_d;
    logic [35:0] tim1_q, tim1_d, tim2_q, tim2_d, tim3_q, tim3_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    phase_t      phase_q, phase_d;
    logic        vs_prev_q, vs_prev_d;

    always_comb begin
        rel_x  = hcount_in - 16'(XPOS);
        rel_y  = vcount_in - 16'(YPOS);
        col    = 8'(rel_x >> (3 + SH));
        row    = 8'(rel_y >> (4 + SH));
        in_box = ({16'd0, hcount_in} >= X_LO) && ({16'd0, hcount_in} < X_HI) &&
                 ({16'd0, vcount_in} >= Y_LO) && ({16'd0, vcount_in} < Y_HI);

        // Stage 1: cell address, sampled enable and cursor match
        char_col_d = in_box ? col : char_col_q;
        char_row_d = in_box ? row : char_row_q;
        inbox1_d   = in_box;
        en1_d      = enable;
        cur1_d     = in_box && cursor_en && (col == cursor_col) && (row == cursor_row);
        line1_d    = rel_y[SH+3:SH];
        bit1_d     = ~rel_x[SH+2:SH];
        rgb1_d     = rgb_in;
        tim1_d     = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};

        // Stage 2: glyph address from the text-buffer code
        font_addr_d = {char_code, line1_q};
        inbox2_d    = inbox1_q;
        en2_d       = en1_q;
        cur2_d      = cur1_q;
        bit2_d      = bit1_q;
        rgb2_d      = rgb1_q;
        tim2_d      = tim1_q;

        // Stage 3: composite; the cursor cell swaps foreground and background
        pix  = font_line[bit2_q];
        fg_c = FG_COLOR;
        bg_c = BG_OPAQUE ? BG_COLOR : rgb2_q;
        if (cur2_q && (phase_q == PHASE_ON)) begin
            fg_c = BG_OPAQUE ? BG_COLOR : rgb2_q;
            bg_c = FG_COLOR;
        end
        rgb_out_d = (inbox2_q && en2_q) ? (pix ? fg_c : bg_c) : rgb2_q;
        tim3_d    = tim2_q;

        vs_prev_d   = vsync_in;
        frame_cnt_d = frame_cnt_q;
        phase_d     = phase_q;
        if (vsync_in && !vs_prev_q) begin
            if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = '0;
                phase_d     = (phase_q == PHASE_ON) ? PHASE_OFF : PHASE_ON;
            end else begin
                frame_cnt_d = frame_cnt_q + FW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_col_q  <= '0;
            char_row_q  <= '0;
            font_addr_q <= '0;
            rgb1_q      <= '0;
            rgb2_q      <= '0;
            rgb_out_q   <= '0;
            inbox1_q    <= 1'b0;
            inbox2_q    <= 1'b0;
            en1_q       <= 1'b0;
            en2_q       <= 1'b0;
            cur1_q      <= 1'b0;
            cur2_q      <= 1'b0;
            line1_q     <= '0;
            bit1_q      <= '0;
            bit2_q      <= '0;
            tim1_q      <= '0;
            tim2_q      <= '0;
            tim3_q      <= '0;
            frame_cnt_q <= '0;
            phase_q     <= PHASE_ON;
            vs_prev_q   <= 1'b0;
        end else begin
            char_col_q  <= char_col_d;
            char_row_q  <= char_row_d;
            font_addr_q <= font_addr_d;
            rgb1_q      <= rgb1_d;
            rgb2_q      <= rgb2_d;
            rgb_out_q   <= rgb_out_d;
            inbox1_q    <= inbox1_d;
            inbox2_q    <= inbox2_d;
            en1_q       <= en1_d;
            en2_q       <= en2_d;
            cur1_q      <= cur1_d;
            cur2_q      <= cur2_d;
            line1_q     <= line1_d;
            bit1_q      <= bit1_d;
            bit2_q      <= bit2_d;
            tim1_q      <= tim1_d;
            tim2_q      <= tim2_d;
            tim3_q      <= tim3_d;
            frame_cnt_q <= frame_cnt_d;
            phase_q     <= phase_d;
            vs_prev_q   <= vs_prev_d;
        end
    end

    assign char_col    = char_col_q;
    assign char_row    = char_row_q;
    assign font_addr   = font_addr_q;
    assign rgb_out     = rgb_out_q;
    assign blink_phase = (phase_q == PHASE_ON);
    assign {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} = tim3_q;
endmodule

// File: tb/tb_draw_rect_text.sv
// Directed bench for draw_rect_text: box geometry, glyph addressing, cursor blink,
// enable pipelining, async reset and a randomised timing pass-through sweep.
module tb_draw_rect_text;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in;
    logic [7:0]  char_col, char_row;
    logic [6:0]  char_code;
    logic [10:0] font_addr;
    logic [7:0]  font_line;
    logic        cursor_en;
    logic [7:0]  cursor_col, cursor_row;
    logic [15:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;
    logic        blink_phase;

    int n_vec = 0;
    int n_err = 0;
    bit zero_chk = 1'b0;

    logic [15:0] px_h[16], px_v[16];
    logic [11:0] px_rgb[16], exp_rgb[16];
    logic        px_en[16], px_cf[16];
    logic [7:0]  exp_cc[16], exp_cr[16];
    logic [10:0] exp_fa[16];
    logic [47:0] exp_q[$];

    draw_rect_text #(
        .XPOS(100), .YPOS(50), .COLS(4), .ROWS(2), .SCALE(2),
        .FG_COLOR(12'hfff), .BG_COLOR(12'h000), .BG_OPAQUE(1'b0), .BLINK_FRAMES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .char_col(char_col), .char_row(char_row), .char_code(char_code),
        .font_addr(font_addr), .font_line(font_line), .cursor_en(cursor_en),
        .cursor_col(cursor_col), .cursor_row(cursor_row),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out), .blink_phase(blink_phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_px(input int i, input logic [15:0] h, input logic [15:0] v,
                          input logic [11:0] r, input logic en, input logic [11:0] er,
                          input logic [7:0] cc, input logic [7:0] cr,
                          input logic cf, input logic [10:0] fa);
        px_h[i] = h; px_v[i] = v; px_rgb[i] = r; px_en[i] = en; exp_rgb[i] = er;
        exp_cc[i] = cc; exp_cr[i] = cr; px_cf[i] = cf; exp_fa[i] = fa;
    endtask

    task automatic drive(input logic [15:0] h, input logic [15:0] v,
                         input logic [11:0] r, input logic en);
        hcount_in = h; vcount_in = v; rgb_in = r; enable = en;
        hsync_in = h[1]; hblnk_in = h[2]; vblnk_in = v[0]; vsync_in = 1'b0;
    endtask

    // Streams n pixels back to back and checks each at its own latency.
    task automatic play(input int n, input string tag);
        logic [35:0] et;
        for (int c = 0; c < n + 3; c++) begin
            @(negedge clk);
            if (c >= 1 && c - 1 < n) begin
                check({tag, ".char_col"}, 48'(char_col), 48'(exp_cc[c-1]));
                check({tag, ".char_row"}, 48'(char_row), 48'(exp_cr[c-1]));
            end
            if (c >= 2 && c - 2 < n && px_cf[c-2])
                check({tag, ".font_addr"}, 48'(font_addr), 48'(exp_fa[c-2]));
            if (c >= 3) begin
                et = {px_h[c-3], px_v[c-3], px_h[c-3][1], 1'b0, px_h[c-3][2], px_v[c-3][0]};
                check({tag, ".rgb_out"}, 48'(rgb_out), 48'(exp_rgb[c-3]));
                check({tag, ".timing"},
                      48'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
                      48'(et));
            end
            if (zero_chk && c >= 1 && c <= 2)
                check({tag, ".rgb_zero"}, 48'(rgb_out), 48'(0));
            if (c < n) drive(px_h[c], px_v[c], px_rgb[c], px_en[c]);
            else drive(16'd0, 16'd0, 12'd0, 1'b0);
        end
        zero_chk = 1'b0;
    endtask

    task automatic vs_pulse();
        @(negedge clk); vsync_in = 1'b1;
        @(negedge clk); vsync_in = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(16'd0, 16'd0, 12'd0, 1'b0);
        char_code = 7'h41; font_line = 8'h80;
        cursor_en = 1'b0; cursor_col = 8'd0; cursor_row = 8'd0;
        repeat (3) @(negedge clk);
        check("reset.rgb_out", 48'(rgb_out), 48'(0));
        check("reset.char", 48'({char_col, char_row, font_addr}), 48'(0));
        check("reset.blink", 48'(blink_phase), 48'(1));
        rst_n = 1'b1;

        // First cell, first glyph line; 8'h80 lights only the leftmost doubled pixel
        set_px(0, 100, 50, 12'h111, 1, 12'hfff, 0, 0, 1, 11'h410);
        set_px(1, 101, 50, 12'h222, 1, 12'hfff, 0, 0, 1, 11'h410);
        set_px(2, 102, 50, 12'h333, 1, 12'h333, 0, 0, 1, 11'h410);
        play(3, "first_px");

        char_code = 7'h2a; font_line = 8'h24;
        set_px(0, 104, 50, 12'h401, 1, 12'hfff, 0, 0, 1, 11'h2a0);
        set_px(1, 106, 50, 12'h402, 1, 12'h402, 0, 0, 1, 11'h2a0);
        set_px(2, 110, 50, 12'h403, 1, 12'hfff, 0, 0, 1, 11'h2a0);
        set_px(3, 114, 50, 12'h404, 1, 12'h404, 0, 0, 1, 11'h2a0);
        play(4, "bit_sel");

        char_code = 7'h41; font_line = 8'h00;
        set_px(0, 116, 83, 12'h501, 1, 12'h501, 1, 1, 1, 11'h410);
        set_px(1, 116, 81, 12'h502, 1, 12'h502, 1, 0, 1, 11'h41f);
        play(2, "row_line");

        font_line = 8'h01;
        set_px(0, 163, 113, 12'h601, 1, 12'hfff, 3, 1, 1, 11'h41f);
        set_px(1,  99,  60, 12'h602, 1, 12'h602, 3, 1, 0, 11'h0);
        set_px(2, 164,  60, 12'h603, 1, 12'h603, 3, 1, 0, 11'h0);
        set_px(3, 120,  49, 12'h604, 1, 12'h604, 3, 1, 0, 11'h0);
        set_px(4, 120, 114, 12'h605, 1, 12'h605, 3, 1, 0, 11'h0);
        play(5, "edges");

        // Cursor on cell (1,0) with a blank glyph: shows FG while blink_phase is 1
        font_line = 8'h00; cursor_en = 1'b1; cursor_col = 8'd1; cursor_row = 8'd0;
        set_px(0, 120, 60, 12'h123, 1, 12'hfff, 1, 0, 1, 11'h415);
        set_px(1, 104, 60, 12'h456, 1, 12'h456, 0, 0, 1, 11'h415);
        set_px(2, 163, 60, 12'h789, 1, 12'h789, 3, 0, 1, 11'h415);
        play(3, "cursor_on");
        vs_pulse(); vs_pulse();
        check("blink_off", 48'(blink_phase), 48'(0));
        set_px(0, 120, 60, 12'h123, 1, 12'h123, 1, 0, 1, 11'h415);
        play(3, "cursor_off");
        vs_pulse(); vs_pulse();
        set_px(0, 120, 60, 12'h123, 1, 12'hfff, 1, 0, 1, 11'h415);
        play(3, "cursor_back");
        cursor_col = 8'd4;
        set_px(0, 120, 60, 12'h123, 1, 12'h123, 1, 0, 1, 11'h415);
        play(3, "cursor_outside");
        vs_pulse(); vs_pulse();
        check("blink_pre_reset", 48'(blink_phase), 48'(0));

        cursor_en = 1'b0; font_line = 8'hff;
        set_px(0, 108, 50, 12'h0a1, 0, 12'h0a1, 0, 0, 1, 11'h410);
        set_px(1, 109, 50, 12'h0a2, 0, 12'h0a2, 0, 0, 1, 11'h410);
        set_px(2, 110, 50, 12'h0a3, 1, 12'hfff, 0, 0, 1, 11'h410);
        set_px(3, 111, 50, 12'h0a4, 1, 12'hfff, 0, 0, 1, 11'h410);
        play(4, "enable");

        // Asynchronous reset in the middle of a box run
        repeat (4) begin
            @(negedge clk); drive(16'd120, 16'd61, 12'h777, 1'b1);
        end
        check("pre_reset.rgb_out", 48'(rgb_out), 48'(12'hfff));
        #2 rst_n = 1'b0;
        #1;
        check("rst.rgb_out", 48'(rgb_out), 48'(0));
        check("rst.char", 48'({char_col, char_row, font_addr}), 48'(0));
        check("rst.timing", 48'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}), 48'(0));
        check("rst.blink", 48'(blink_phase), 48'(1));
        drive(16'd0, 16'd0, 12'd0, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        zero_chk = 1'b1;
        set_px(0, 120, 60, 12'h777, 1, 12'hfff, 1, 0, 1, 11'h415);
        play(1, "post_reset");

        // Random full-frame coordinates with the overlay disabled
        for (int k = 0; k < 3000; k++) begin
            logic [47:0] e;
            @(negedge clk);
            if (exp_q.size() == 3) begin
                e = exp_q.pop_front();
                check("sweep", 48'({hcount_out, vcount_out, hsync_out, vsync_out,
                                   hblnk_out, vblnk_out, rgb_out}), e);
            end
            hcount_in = 16'($urandom_range(0, 799));
            vcount_in = 16'($urandom_range(0, 599));
            hsync_in = 1'($urandom_range(0, 1)); vsync_in = 1'($urandom_range(0, 1));
            hblnk_in = 1'($urandom_range(0, 1)); vblnk_in = 1'($urandom_range(0, 1));
            rgb_in = 12'($urandom_range(0, 4095)); enable = 1'b0;
            exp_q.push_back({hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
